// File: rtl/step_judge_pkg.sv
// Shared constants and types for the step judge: lane count, score weights
// and the judgement encoding.
package step_judge_pkg;

   localparam int unsigned NUM_LANES   = 4;
   localparam int unsigned PERFECT_PTS = 3;
   localparam int unsigned GOOD_PTS    = 1;

   typedef enum logic [2:0] {
      J_NONE,
      J_PERFECT,
      J_GOOD,
      J_MISS,
      J_STRAY
   } judge_t;

endpackage

// File: rtl/lane_note_fifo.sv
// Per-lane queue of pending note due-times. A push into a full queue is
// accepted when a pop happens in the same cycle.
module lane_note_fifo
   import step_judge_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TS_W  = 32
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            push,
   input  logic [TS_W-1:0] push_data,
   input  logic            pop,
   output logic            full,
   output logic            empty,
   output logic [TS_W-1:0] head
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [TS_W-1:0] mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Storage write; contents are don't-care while the queue is empty.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/step_judge.sv
// Receives lane drop strobes and step buttons, judges each press against the
// oldest pending note of its lane, and accumulates score and combo.
module step_judge
   import step_judge_pkg::*;
#(
   parameter int unsigned TRAVEL      = 50_000_000,
   parameter int unsigned GOOD_WIN    = 5_000_000,
   parameter int unsigned PERFECT_WIN = 2_000_000,
   parameter int unsigned TS_W        = 32,
   parameter int unsigned DEPTH       = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        drop_valid,
   input  logic [3:0]  drop_lane,
   input  logic [3:0]  keys,
   output logic [3:0]  hit_perfect,
   output logic [3:0]  hit_good,
   output logic [3:0]  miss,
   output logic [3:0]  stray,
   output logic [15:0] score,
   output logic [7:0]  combo,
   output logic [7:0]  max_combo,
   output logic        overflow
);

   localparam logic signed [TS_W-1:0] GW_POS = TS_W'(GOOD_WIN);
   localparam logic signed [TS_W-1:0] GW_NEG = -GW_POS;
   localparam logic signed [TS_W-1:0] PW_POS = TS_W'(PERFECT_WIN);
   localparam logic signed [TS_W-1:0] PW_NEG = -PW_POS;

   logic [TS_W-1:0]        now;
   logic [TS_W-1:0]        due_new;
   logic [3:0]             sync1, sync2, key_prev, armed;
   logic [1:0]             live;
   logic [3:0]             press, push, pop, full, empty;
   logic [TS_W-1:0]        head [NUM_LANES];
   logic signed [TS_W-1:0] diff [NUM_LANES];
   judge_t                 verdict [NUM_LANES];
   logic [3:0]             j_perf, j_good, j_miss, j_stray;
   logic [2:0]             n_perf, n_good;
   logic [16:0]            score_sum;
   logic [8:0]             combo_sum;
   logic [7:0]             combo_next;
   logic                   overflow_set;

   assign due_new = now + TS_W'(TRAVEL);
   assign push    = drop_lane & {4{drop_valid}};
   // A key held through reset release stays unarmed until it is seen low,
   // so it cannot fake a press on the first cycles after reset.
   assign press   = sync2 & ~key_prev & armed;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_note_fifo #(
         .DEPTH (DEPTH),
         .TS_W  (TS_W)
      ) u_fifo (
         .clock     (clock),
         .resetn    (resetn),
         .push      (push[i]),
         .push_data (due_new),
         .pop       (pop[i]),
         .full      (full[i]),
         .empty     (empty[i]),
         .head      (head[i])
      );
      assign diff[i] = $signed(now - head[i]);
   end

   // Per-lane judgement: expiry first, then the press against the head note.
   always_comb begin
      pop     = '0;
      j_perf  = '0;
      j_good  = '0;
      j_miss  = '0;
      j_stray = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         verdict[i] = J_NONE;
         if (!empty[i] && diff[i] > GW_POS) begin
            j_miss[i] = 1'b1;
            pop[i]    = 1'b1;
            if (press[i]) verdict[i] = J_STRAY;
         end else if (press[i]) begin
            if (empty[i] || diff[i] < GW_NEG) begin
               verdict[i] = J_STRAY;
            end else if (diff[i] >= PW_NEG && diff[i] <= PW_POS) begin
               verdict[i] = J_PERFECT;
               pop[i]     = 1'b1;
            end else begin
               verdict[i] = J_GOOD;
               pop[i]     = 1'b1;
            end
         end
         j_perf[i]  = (verdict[i] == J_PERFECT);
         j_good[i]  = (verdict[i] == J_GOOD);
         j_stray[i] = (verdict[i] == J_STRAY);
      end
   end

   // Score and combo arithmetic for this cycle's judgements.
   always_comb begin
      n_perf = '0;
      n_good = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         n_perf = n_perf + 3'(j_perf[i]);
         n_good = n_good + 3'(j_good[i]);
      end
      score_sum    = {1'b0, score} + 17'(n_perf * PERFECT_PTS) + 17'(n_good * GOOD_PTS);
      combo_sum    = {1'b0, combo} + 9'(n_perf) + 9'(n_good);
      combo_next   = (|j_miss) ? '0 : (combo_sum[8] ? '1 : combo_sum[7:0]);
      overflow_set = |(push & full & ~pop);
   end

   // Timestamp, key synchronizers and all registered outputs.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         now         <= '0;
         sync1       <= '0;
         sync2       <= '0;
         key_prev    <= '0;
         armed       <= '0;
         live        <= '0;
         hit_perfect <= '0;
         hit_good    <= '0;
         miss        <= '0;
         stray       <= '0;
         score       <= '0;
         combo       <= '0;
         max_combo   <= '0;
         overflow    <= 1'b0;
      end else begin
         now         <= now + 1'b1;
         sync1       <= keys;
         sync2       <= sync1;
         key_prev    <= sync2;
         live        <= {live[0], 1'b1};
         armed       <= armed | ({4{live[1]}} & ~sync2);
         hit_perfect <= j_perf;
         hit_good    <= j_good;
         miss        <= j_miss;
         stray       <= j_stray;
         score       <= score_sum[16] ? '1 : score_sum[15:0];
         combo       <= combo_next;
         if (combo_next > max_combo) max_combo <= combo_next;
         overflow    <= overflow | overflow_set;
      end
   end

endmodule

// File: tb/tb_step_judge.sv
// Self-checking bench for step_judge: scenario tasks push expected judgement
// pulses into a scoreboard queue, a monitor compares them as the DUT emits.
module tb_step_judge;

   localparam int P = 0, G = 1, M = 2, S = 3;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        drop_valid = 1'b0;
   logic [3:0]  drop_lane = '0;
   logic [3:0]  keys = '0;
   logic [3:0]  hit_perfect, hit_good, miss, stray;
   logic [15:0] score;
   logic [7:0]  combo, max_combo;
   logic        overflow;

   int checks = 0;
   int failures = 0;
   int tnow = 0;
   int edge_now = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int t;
      int kind;
      int lane;
   } ev_t;
   ev_t expq[$];

   step_judge #(
      .TRAVEL      (100),
      .GOOD_WIN    (10),
      .PERFECT_WIN (4),
      .TS_W        (32),
      .DEPTH       (4)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .drop_valid  (drop_valid),
      .drop_lane   (drop_lane),
      .keys        (keys),
      .hit_perfect (hit_perfect),
      .hit_good    (hit_good),
      .miss        (miss),
      .stray       (stray),
      .score       (score),
      .combo       (combo),
      .max_combo   (max_combo),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   // Model of the DUT timestamp: edge_now is the value sampled at the last edge.
   always @(posedge clock) begin
      edge_now <= tnow;
      tnow     <= resetn ? tnow + 1 : 0;
   end

   // Scoreboard: pop every expectation due at the last edge and compare pulses.
   always @(negedge clock) begin
      logic [3:0] ep, eg, em, es;
      ev_t e;
      if (mon_en) begin
         ep = '0; eg = '0; em = '0; es = '0;
         while (expq.size() > 0 && expq[0].t <= edge_now) begin
            e = expq.pop_front();
            case (e.kind)
               P: ep[e.lane] = 1'b1;
               G: eg[e.lane] = 1'b1;
               M: em[e.lane] = 1'b1;
               default: es[e.lane] = 1'b1;
            endcase
         end
         checks++;
         if ({hit_perfect, hit_good, miss, stray} !== {ep, eg, em, es}) begin
            failures++;
            $display("FAIL pulses now=%0d got p=%b g=%b m=%b s=%b want p=%b g=%b m=%b s=%b",
                     edge_now, hit_perfect, hit_good, miss, stray, ep, eg, em, es);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic goto(input int t);
      while (tnow < t) tick();
   endtask

   task automatic expect_ev(input int t, input int kind, input int lane);
      ev_t e;
      e = '{t, kind, lane};
      expq.push_back(e);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drop_valid = 1'b0;
      drop_lane = '0;
      keys = '0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic drop(input logic [3:0] lanes);
      drop_valid = 1'b1;
      drop_lane = lanes;
      tick();
      drop_valid = 1'b0;
      drop_lane = '0;
   endtask

   task automatic press(input int lane);
      keys[lane] = 1'b1;
      tick();
      keys[lane] = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({hit_perfect, hit_good, miss, stray} !== 16'h0) begin
         failures++; $display("FAIL reset_pulses got=%h want=0", {hit_perfect, hit_good, miss, stray});
      end
      checks++;
      if ({score, combo, max_combo, overflow} !== 33'h0) begin
         failures++; $display("FAIL reset_regs got score=%0d combo=%0d max=%0d ovf=%b want all 0",
                              score, combo, max_combo, overflow);
      end
      resetn = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_perfect();
      do_reset();
      expect_ev(102, P, 2);
      drop(4'b0100);
      goto(100);
      press(2);
      goto(106);
      checks++;
      if (score !== 16'd3) begin failures++; $display("FAIL perfect_score got=%0d want=3", score); end
      checks++;
      if (combo !== 8'd1) begin failures++; $display("FAIL perfect_combo got=%0d want=1", combo); end
      checks++;
      if (max_combo !== 8'd1) begin failures++; $display("FAIL perfect_max got=%0d want=1", max_combo); end
   endtask

   task automatic test_miss();
      do_reset();
      expect_ev(102, P, 1);
      expect_ev(111, M, 0);
      drop(4'b0011);
      goto(100);
      press(1);
      goto(106);
      checks++;
      if (combo !== 8'd1) begin failures++; $display("FAIL miss_precombo got=%0d want=1", combo); end
      goto(113);
      checks++;
      if (score !== 16'd3) begin failures++; $display("FAIL miss_score got=%0d want=3", score); end
      checks++;
      if (combo !== 8'd0) begin failures++; $display("FAIL miss_combo got=%0d want=0", combo); end
      checks++;
      if (max_combo !== 8'd1) begin failures++; $display("FAIL miss_max got=%0d want=1", max_combo); end
   endtask

   task automatic test_stray();
      do_reset();
      expect_ev(85, S, 1);
      expect_ev(85, S, 3);
      expect_ev(108, G, 3);
      drop(4'b1000);
      goto(83);
      keys = 4'b1010;
      tick();
      keys = '0;
      goto(106);
      press(3);
      goto(112);
      checks++;
      if (score !== 16'd1) begin failures++; $display("FAIL stray_score got=%0d want=1", score); end
      checks++;
      if (combo !== 8'd1) begin failures++; $display("FAIL stray_combo got=%0d want=1", combo); end
   endtask

   task automatic test_window();
      do_reset();
      expect_ev(89, S, 3);
      expect_ev(90, G, 0);
      expect_ev(96, P, 1);
      expect_ev(105, G, 2);
      expect_ev(111, M, 3);
      drop(4'b1111);
      goto(87);
      press(3);
      press(0);
      goto(94);
      press(1);
      goto(103);
      press(2);
      goto(106);
      checks++;
      if (combo !== 8'd3) begin failures++; $display("FAIL window_combo got=%0d want=3", combo); end
      goto(113);
      checks++;
      if (score !== 16'd5) begin failures++; $display("FAIL window_score got=%0d want=5", score); end
      checks++;
      if ({combo, max_combo} !== {8'd0, 8'd3}) begin
         failures++; $display("FAIL window_combo_after got=%0d/%0d want=0/3", combo, max_combo);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      expect_ev(100, P, 0);
      expect_ev(102, P, 0);
      expect_ev(104, P, 0);
      expect_ev(106, P, 0);
      drop_valid = 1'b1;
      drop_lane = 4'b0001;
      goto(4);
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b want=0", overflow); end
      tick();
      drop_valid = 1'b0;
      drop_lane = '0;
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", overflow); end
      goto(98);
      press(0);
      goto(100);
      press(0);
      goto(102);
      press(0);
      goto(104);
      press(0);
      goto(120);
      checks++;
      if (score !== 16'd12) begin failures++; $display("FAIL ovf_score got=%0d want=12", score); end
      checks++;
      if ({combo, max_combo} !== {8'd4, 8'd4}) begin
         failures++; $display("FAIL ovf_combo got=%0d/%0d want=4/4", combo, max_combo);
      end
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      expect_ev(100, P, 0);
      expect_ev(112, M, 0);
      expect_ev(113, M, 0);
      expect_ev(114, M, 0);
      expect_ev(211, M, 0);
      drop_valid = 1'b1;
      drop_lane = 4'b0001;
      goto(4);
      drop_valid = 1'b0;
      drop_lane = '0;
      goto(98);
      press(0);
      goto(100);
      drop(4'b0001);
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got=%b want=0", overflow); end
      goto(215);
      checks++;
      if ({score, combo, max_combo} !== {16'd3, 8'd0, 8'd1}) begin
         failures++; $display("FAIL fullpp_regs got=%0d/%0d/%0d want=3/0/1", score, combo, max_combo);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      expect_ev(100, P, 3);
      expect_ev(111, P, 0);
      expect_ev(111, P, 1);
      expect_ev(111, M, 2);
      drop(4'b1100);
      goto(10);
      drop(4'b0011);
      goto(98);
      press(3);
      goto(109);
      keys = 4'b0011;
      tick();
      keys = '0;
      goto(113);
      checks++;
      if (score !== 16'd9) begin failures++; $display("FAIL simul_score got=%0d want=9", score); end
      checks++;
      if (combo !== 8'd0) begin failures++; $display("FAIL simul_combo got=%0d want=0", combo); end
      checks++;
      if (max_combo !== 8'd1) begin failures++; $display("FAIL simul_max got=%0d want=1", max_combo); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      expect_ev(102, P, 3);
      drop(4'b1111);
      goto(100);
      keys[3] = 1'b1;
      goto(104);
      checks++;
      if (score !== 16'd3) begin failures++; $display("FAIL midrst_pre got=%0d want=3", score); end
      resetn = 1'b0;
      tick();
      checks++;
      if ({hit_perfect, hit_good, miss, stray} !== 16'h0) begin
         failures++; $display("FAIL midrst_pulses got=%h want=0", {hit_perfect, hit_good, miss, stray});
      end
      checks++;
      if ({score, combo, max_combo, overflow} !== 33'h0) begin
         failures++; $display("FAIL midrst_regs got score=%0d combo=%0d max=%0d ovf=%b want all 0",
                              score, combo, max_combo, overflow);
      end
      resetn = 1'b1;
      expect_ev(157, S, 3);
      goto(150);
      keys[3] = 1'b0;
      goto(155);
      press(3);
      goto(160);
      checks++;
      if ({score, combo} !== 24'h0) begin
         failures++; $display("FAIL midrst_after got=%0d/%0d want=0/0", score, combo);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_perfect();
      test_miss();
      test_stray();
      test_window();
      test_overflow();
      test_full_push_pop();
      test_simultaneous();
      test_reset_mid();
      tick();
      checks++;
      if (expq.size() != 0) begin
         failures++; $display("FAIL leftover_expect got=%0d want=0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
